// File: rtl/water_inlet_arbiter.sv
// Round-robin arbiter sharing one mains inlet valve and heater between
// several washing-machine controllers. Each grant is bounded by a maximum
// hold time. A valve-settle guard gap, with all grants low, follows every
// release.
module water_inlet_arbiter #(
  parameter int N_MACHINES   = 4,
  parameter int MAX_HOLD     = 8,
  parameter int GUARD_CYCLES = 2
) (
  input  logic                          CLK,
  input  logic                          RST,
  input  logic [N_MACHINES-1:0]         Req,
  input  logic [N_MACHINES-1:0]         Done,
  input  logic [N_MACHINES-1:0]         Abort,
  output logic [N_MACHINES-1:0]         Grant,
  output logic [$clog2(N_MACHINES)-1:0] Grant_Id,
  output logic                          Busy,
  output logic                          Timeout,
  output logic [$clog2(N_MACHINES)-1:0] Timeout_Id
);

  localparam int ID_W   = $clog2(N_MACHINES);
  localparam int HOLD_W = $clog2(MAX_HOLD + 1);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] GRANT = 2'd1;
  localparam logic [1:0] GUARD = 2'd2;

  logic [1:0]            state;
  logic [ID_W-1:0]       rr_ptr;
  logic [HOLD_W-1:0]     hold_cnt;
  logic [3:0]            guard_cnt;

  logic [N_MACHINES-1:0] eligible;
  logic                  win_found;
  logic [ID_W-1:0]       win_id;
  logic [ID_W-1:0]       cand;
  logic                  owner_release;

  // Winner search: first eligible index above the pointer, wrapping around.
  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can
    // leave it unassigned and infer a latch.
    eligible  = Req & ~Abort;
    win_found = 1'b0;
    win_id    = '0;
    cand      = '0;
    // Walk from the farthest offset down to the nearest; the nearest
    // eligible candidate is written last and therefore wins.
    for (int i = N_MACHINES; i >= 1; i--) begin
      cand = ID_W'((int'(rr_ptr) + i) % N_MACHINES);
      if (eligible[cand]) begin
        win_found = 1'b1;
        win_id    = cand;
      end
    end
  end

  // The current owner gives the resource back early on abort, completion or
  // dropped request. These take precedence over the hold limit, so none of
  // them raises Timeout.
  always_comb begin
    owner_release = Abort[Grant_Id] | Done[Grant_Id] | ~Req[Grant_Id];
  end

  // Main FSM: grant, hold accounting, guard interval and timeout pulse.
  always_ff @(posedge CLK) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (RST) begin
      state      <= IDLE;
      Grant      <= '0;
      Grant_Id   <= '0;
      Timeout    <= 1'b0;
      Timeout_Id <= '0;
      rr_ptr     <= ID_W'(N_MACHINES - 1);
      hold_cnt   <= '0;
      guard_cnt  <= '0;
    end else begin
      Timeout <= 1'b0;
      case (state)
        IDLE: begin
          if (win_found) begin
            state    <= GRANT;
            Grant    <= N_MACHINES'(1) << win_id;
            Grant_Id <= win_id;
            rr_ptr   <= win_id;
            hold_cnt <= HOLD_W'(1);
          end
        end

        GRANT: begin
          if (owner_release || hold_cnt == HOLD_W'(MAX_HOLD)) begin
            state      <= GUARD;
            Grant      <= '0;
            hold_cnt   <= '0;
            guard_cnt  <= 4'd1;
            Timeout    <= ~owner_release;
            Timeout_Id <= Grant_Id;
          end else begin
            hold_cnt <= hold_cnt + HOLD_W'(1);
          end
        end

        GUARD: begin
          if (guard_cnt == 4'(GUARD_CYCLES)) begin
            guard_cnt <= '0;
            if (win_found) begin
              state    <= GRANT;
              Grant    <= N_MACHINES'(1) << win_id;
              Grant_Id <= win_id;
              rr_ptr   <= win_id;
              hold_cnt <= HOLD_W'(1);
            end else begin
              state <= IDLE;
            end
          end else begin
            guard_cnt <= guard_cnt + 4'd1;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

  // Busy covers both the grant and the guard interval.
  always_comb begin
    Busy = (state != IDLE);
  end

endmodule

// File: tb/tb_water_inlet_arbiter.sv
// Self-checking bench for water_inlet_arbiter. A behavioural model tracks
// the owner, how long it has held the resource and the remaining settle gap.
// A compare process checks the DUT against that model on every cycle, and
// directed scenarios add hand-computed literal checks.
module tb_water_inlet_arbiter;

  localparam int N  = 4;
  localparam int MH = 8;
  localparam int GC = 2;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic [3:0] Req = '0;
  logic [3:0] Done = '0;
  logic [3:0] Abort = '0;
  logic [3:0] Grant;
  logic [1:0] Grant_Id;
  logic       Busy;
  logic       Timeout;
  logic [1:0] Timeout_Id;

  water_inlet_arbiter #(
    .N_MACHINES(N), .MAX_HOLD(MH), .GUARD_CYCLES(GC)
  ) dut (
    .CLK(CLK), .RST(RST), .Req(Req), .Done(Done), .Abort(Abort),
    .Grant(Grant), .Grant_Id(Grant_Id), .Busy(Busy),
    .Timeout(Timeout), .Timeout_Id(Timeout_Id)
  );

  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_pass   = 0;
  bit cmp_en   = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Behavioural model: the owner index (-1 = none), the cycles it has held
  // the resource, and the guard cycles still left to run.
  int m_owner = -1;
  int m_held  = 0;
  int m_gap   = 0;
  int m_ptr   = N - 1;
  int m_last  = 0;
  bit m_to    = 1'b0;
  int m_to_id = 0;

  task automatic model_release(input bit timed_out);
    m_to    = timed_out;
    m_to_id = m_owner;
    m_owner = -1;
    m_held  = 0;
    m_gap   = GC;
  endtask

  task automatic model_arbitrate();
    for (int k = 1; k <= N; k++) begin
      int idx;
      idx = (m_ptr + k) % N;
      if (Req[idx] && !Abort[idx]) begin
        m_owner = idx;
        m_held  = 1;
        m_ptr   = idx;
        m_last  = idx;
        break;
      end
    end
  endtask

  always @(posedge CLK) begin
    if (RST) begin
      m_owner = -1; m_held = 0; m_gap = 0; m_ptr = N - 1;
      m_last = 0; m_to = 1'b0; m_to_id = 0;
    end else begin
      m_to = 1'b0;
      if (m_owner >= 0) begin
        if (Abort[m_owner] || Done[m_owner] || !Req[m_owner]) model_release(1'b0);
        else if (m_held == MH) model_release(1'b1);
        else m_held++;
      end else if (m_gap > 1) begin
        m_gap--;
      end else begin
        m_gap = 0;
        model_arbitrate();
      end
    end
  end

  // Compare the DUT against the model on the falling edge.
  always @(negedge CLK) begin
    if (cmp_en) begin
      logic [3:0] exp_g;
      exp_g = (m_owner >= 0) ? (4'b0001 << m_owner) : 4'b0000;
      check("model_grant", Grant, exp_g);
      check("model_busy", Busy, (m_owner >= 0 || m_gap > 0));
      check("model_grant_id", Grant_Id, m_last);
      check("model_timeout", Timeout, m_to);
      if (m_to) check("model_timeout_id", Timeout_Id, m_to_id);
    end
  end

  task automatic step(input logic [3:0] r, input logic [3:0] d, input logic [3:0] a);
    Req = r; Done = d; Abort = a;
    @(posedge CLK); #1;
  endtask

  task automatic reset_dut();
    RST = 1'b1;
    step(4'b0, 4'b0, 4'b0);
    RST = 1'b0;
  endtask

  // Per-cycle log: entry c+1 holds the outputs seen after stimulus cycle c.
  logic [3:0] g_log   [0:63];
  logic       t_log   [0:63];
  logic [1:0] tid_log [0:63];

  task automatic run(input logic [3:0] r, input int ev, input logic [3:0] d,
                     input logic [3:0] a, input int n);
    for (int c = 0; c < n; c++) begin
      step(r, (c == ev) ? d : 4'b0, (c == ev) ? a : 4'b0);
      g_log[c+1]   = Grant;
      t_log[c+1]   = Timeout;
      tid_log[c+1] = Timeout_Id;
    end
  endtask

  initial begin
    int order [0:15];
    int norder;
    int exp_order [0:5];
    logic [3:0] prev_g;
    logic seen_to;
    int glen;

    // Reset state.
    reset_dut();
    cmp_en = 1'b1;
    check("rst_grant", Grant, 4'b0000);
    check("rst_grant_id", Grant_Id, 2'd0);
    check("rst_busy", Busy, 1'b0);
    check("rst_timeout", Timeout, 1'b0);
    check("rst_timeout_id", Timeout_Id, 2'd0);

    // Single request, then Done; the grant appears one cycle after Req.
    repeat (3) step(4'b0000, 4'b0000, 4'b0000);
    step(4'b0001, 4'b0000, 4'b0000);
    check("s1_grant", Grant, 4'b0001);
    check("s1_busy", Busy, 1'b1);
    check("s1_grant_id", Grant_Id, 2'd0);
    repeat (4) step(4'b0001, 4'b0000, 4'b0000);
    check("s1_grant_held", Grant, 4'b0001);
    step(4'b0001, 4'b0001, 4'b0000);
    check("s1_guard1_grant", Grant, 4'b0000);
    check("s1_guard1_busy", Busy, 1'b1);
    check("s1_guard1_timeout", Timeout, 1'b0);
    step(4'b0000, 4'b0000, 4'b0000);
    check("s1_guard2_busy", Busy, 1'b1);
    step(4'b0000, 4'b0000, 4'b0000);
    check("s1_idle_busy", Busy, 1'b0);
    check("s1_idle_grant_id", Grant_Id, 2'd0);

    // All machines request; Done on the third cycle of each grant.
    reset_dut();
    norder = 0; prev_g = '0; seen_to = 1'b0;
    for (int c = 0; c < 60; c++) begin
      logic [3:0] d;
      d = (c % 5 == 3) ? (4'b0001 << ((c / 5) % 4)) : 4'b0000;
      step(4'b1111, d, 4'b0000);
      if (Grant != 4'b0000 && prev_g == 4'b0000 && norder < 16) begin
        for (int k = 0; k < 4; k++) if (Grant[k]) order[norder] = k;
        norder++;
      end
      prev_g  = Grant;
      seen_to = seen_to | Timeout;
    end
    exp_order = '{0, 1, 2, 3, 0, 1};
    for (int k = 0; k < 6; k++) check("s2_order", order[k], exp_order[k]);
    check("s2_num_grants", norder, 12);
    check("s2_no_timeout", seen_to, 1'b0);

    // Lone requester with no Done: timeout after MAX_HOLD, then re-grant.
    reset_dut();
    run(4'b0100, -1, 4'b0, 4'b0, 12);
    glen = 0;
    for (int c = 1; c <= 10; c++) if (g_log[c] == 4'b0100) glen++;
    check("s3_hold_len", glen, MH);
    check("s3_grant_c1", g_log[1], 4'b0100);
    check("s3_drop_c9", g_log[9], 4'b0000);
    check("s3_timeout_c9", t_log[9], 1'b1);
    check("s3_timeout_id_c9", tid_log[9], 2'd2);
    check("s3_timeout_c10", t_log[10], 1'b0);
    check("s3_gap_c10", g_log[10], 4'b0000);
    check("s3_regrant_c11", g_log[11], 4'b0100);

    // Two requesters: the timed-out machine yields to the other one.
    reset_dut();
    run(4'b0110, -1, 4'b0, 4'b0, 12);
    check("s4_grant_c1", g_log[1], 4'b0010);
    check("s4_grant_c8", g_log[8], 4'b0010);
    check("s4_timeout_c9", t_log[9], 1'b1);
    check("s4_timeout_id_c9", tid_log[9], 2'd1);
    check("s4_next_c11", g_log[11], 4'b0100);

    // Abort and Done together at the hold limit: release without timeout.
    reset_dut();
    run(4'b1000, 8, 4'b1000, 4'b1000, 11);
    check("s5a_grant_c8", g_log[8], 4'b1000);
    check("s5a_drop_c9", g_log[9], 4'b0000);
    check("s5a_no_timeout", t_log[9], 1'b0);

    // Done alone at the hold limit: release without timeout.
    reset_dut();
    run(4'b1000, 8, 4'b1000, 4'b0000, 11);
    check("s5b_drop_c9", g_log[9], 4'b0000);
    check("s5b_no_timeout", t_log[9], 1'b0);

    // Reset in the middle of a grant.
    reset_dut();
    repeat (3) step(4'b0100, 4'b0000, 4'b0000);
    check("s6_pre_grant", Grant, 4'b0100);
    RST = 1'b1;
    step(4'b0100, 4'b0000, 4'b0000);
    RST = 1'b0;
    check("s6_rst_grant", Grant, 4'b0000);
    check("s6_rst_busy", Busy, 1'b0);
    check("s6_rst_timeout", Timeout, 1'b0);
    step(4'b1111, 4'b0000, 4'b0000);
    check("s6_first_grant", Grant, 4'b0001);
    check("s6_first_id", Grant_Id, 2'd0);
    repeat (4) step(4'b0000, 4'b0000, 4'b0000);

    cmp_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/water_inlet_arbiter.md
Name: water_inlet_arbiter

Overview:
- Shares one mains water inlet valve and heater between N washing-machine controllers in a multi-machine (laundromat) build.
- Each machine controller raises Req while in its fill or heat phase. The arbiter grants exclusive use to one machine at a time using round-robin order.
- Each grant is bounded by a maximum hold time. Between grants the arbiter enforces a valve-settle guard interval.

Parameters:
N_MACHINES, 4, number of requesting machine controllers; legal range 2..8
MAX_HOLD, 8, maximum consecutive cycles one grant may stay high; legal range 2..255
GUARD_CYCLES, 2, all-grants-low cycles inserted after every release; legal range 1..15

Ports:
CLK  input  1  system clock, rising edge
RST  input  1  synchronous, active-high reset
Req  input  N_MACHINES  per-machine request; level, held while the resource is wanted
Done  input  N_MACHINES  per-machine completion pulse; only the bit of the granted machine is used
Abort  input  N_MACHINES  per-machine stop/failure; releases the grant immediately and masks that requester
Grant  output  N_MACHINES  registered one-hot grant, all zero when no grant is active
Grant_Id  output  clog2(N_MACHINES)  index of the current or most recent grantee
Busy  output  1  high whenever the FSM is not IDLE
Timeout  output  1  one-cycle pulse when a grant is revoked because MAX_HOLD was reached
Timeout_Id  output  clog2(N_MACHINES)  index of the revoked machine; valid while Timeout=1

Behaviour:
- Reset (RST=1 at a rising edge):
  - Grant=0, Grant_Id=0, Busy=0, Timeout=0, Timeout_Id=0.
  - FSM=IDLE, hold counter=0, guard counter=0.
  - Round-robin pointer=N_MACHINES-1, so machine 0 has first priority.
  - Reset mid-grant drops Grant on the next edge with no Timeout pulse.
- Eligible set: Req & ~Abort, evaluated each cycle.
- Winner selection: first eligible index searching upward from pointer+1, wrapping modulo N_MACHINES.
- States:
  - IDLE: if the eligible set is non-empty, go to GRANT. Grant[winner]=1 and Grant_Id=winner from the next cycle (1-cycle latency from Req). Pointer=winner, hold counter=1. Otherwise stay in IDLE.
  - GRANT: Grant held steady. Each cycle, in priority order:
    - (1) Abort[id]: release.
    - (2) Done[id] or Req[id]=0: release.
    - (3) hold counter==MAX_HOLD: release with timeout. Timeout=1 and Timeout_Id=id during the first GUARD cycle.
    - Else hold counter+1.
    - Done and the hold limit in the same cycle: Done wins, no Timeout.
    - Release means go to GUARD with Grant=0 on the next cycle and guard counter=1.
  - GUARD: Grant=0 for exactly GUARD_CYCLES cycles. In the last guard cycle, arbitrate as in IDLE: if a winner exists, go directly to GRANT; else go to IDLE. The gap between grants is therefore exactly GUARD_CYCLES cycles.
- Grant is high for at most MAX_HOLD consecutive cycles.
- A timed-out machine keeps its Req. It is re-served only after the pointer rotates past the other eligible requesters.
- Fairness: with all N requesting continuously, grants rotate 0,1,..,N-1,0. No machine waits more than (N_MACHINES-1)*(MAX_HOLD+GUARD_CYCLES)+GUARD_CYCLES cycles.
- Done or Abort on a non-granted index is ignored, apart from Abort masking that requester for the cycle.
- Req rising during GUARD is honoured at the last guard cycle.
- Counters: hold counter width clog2(MAX_HOLD+1), guard counter 4 bits. Neither may wrap; each is cleared on release and on reset.
- Grant_Id retains its last value in IDLE/GUARD.
- Busy=1 in GRANT and GUARD.

Test Plan:
- N=4, MAX_HOLD=8, GUARD_CYCLES=2:
  - Reset release, then Req=0001 at cycle 10 -> Grant=0001 at cycle 11, Busy=1, Grant_Id=0.
  - Done[0] at cycle 15 -> Grant=0000 at cycles 16-17, Busy=1 through 17, then IDLE at 18.
- Req=1111 held for 60 cycles with Done pulsed on each grant's 3rd cycle -> grant order 0,1,2,3,0,1.
  - Each grant is 3 cycles long with a 2-cycle zero gap between grants.
  - Timeout never asserted.
- Req=0100 held, no Done -> Grant=0100 for exactly 8 cycles.
  - Timeout=1 with Timeout_Id=2 in the first guard cycle.
  - Re-grant of machine 2 two cycles after the drop.
- Req=0110, no Done -> machine 1 times out after 8 cycles, then machine 2 is granted after a 2-cycle gap rather than machine 1 again.
- Abort[3] while Grant=1000, with Done[3] and hold limit reached in the same cycle -> Grant drops next cycle and no Timeout pulse.
  - Separately, Done[3] exactly at hold cycle 8 -> no Timeout.
- RST=1 for one cycle during GRANT of machine 2 -> Grant=0000 and Busy=0 next cycle.
  - With Req=1111 afterwards, the first grant is machine 0.
